// File: rtl/ex_flag_stage_pkg.sv
// ex_flag_stage_pkg: shared widths, flag-update encodings, flag struct and overflow helper
package ex_flag_stage_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 4;
  localparam int SATCNT_W = 16;
  localparam logic [1:0] FLAG_UPD_NONE = 2'b00;
  localparam logic [1:0] FLAG_UPD_Z = 2'b01;
  localparam logic [1:0] FLAG_UPD_ALL = 2'b10;
  localparam logic [1:0] FLAG_UPD_RSVD = 2'b11;
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;
  // signed overflow: operands agree in sign (after subtract inversion) but the raw sum does not
  function automatic logic sovf(input logic a_msb, input logic b_msb, input logic sub, input logic raw_msb);
    return (a_msb == (b_msb ^ sub)) & (raw_msb != a_msb);
  endfunction
endpackage

// File: rtl/ex_flag_stage_if.sv
// ex_flag_stage_if: execute-to-EX/MEM bundle with adder inputs, pipeline control and stage outputs
interface ex_flag_stage_if;
  import ex_flag_stage_pkg::*;
  logic in_valid;
  logic [DATA_W-1:0] in_result;
  logic in_raw_msb;
  logic in_a_msb;
  logic in_b_msb;
  logic in_sub;
  logic [1:0] in_flag_upd;
  logic [REG_W-1:0] in_rd;
  logic in_wr_en;
  logic stall;
  logic flush;
  logic satcnt_clr;
  logic out_valid;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0] out_rd;
  logic out_wr_en;
  logic flag_z;
  logic flag_v;
  logic flag_n;
  logic [SATCNT_W-1:0] sat_count;
  modport master (
    output in_valid, in_result, in_raw_msb, in_a_msb, in_b_msb, in_sub, in_flag_upd, in_rd, in_wr_en,
    output stall, flush, satcnt_clr,
    input out_valid, out_result, out_rd, out_wr_en, flag_z, flag_v, flag_n, sat_count
  );
  modport slave (
    input in_valid, in_result, in_raw_msb, in_a_msb, in_b_msb, in_sub, in_flag_upd, in_rd, in_wr_en,
    input stall, flush, satcnt_clr,
    output out_valid, out_result, out_rd, out_wr_en, flag_z, flag_v, flag_n, sat_count
  );
endinterface

// File: rtl/ex_flag_stage_sat_counter.sv
// sat_counter: counter that sticks at all-ones, with a clear that beats increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise increment unless already saturated
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: registers the saturated adder result into EX/MEM and maintains Z/V/N flags and a saturation count
module ex_flag_stage
  import ex_flag_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_flag_stage_if.slave bus
);
  logic accept, hold, v_new, z_new;
  logic valid_q, valid_d, wr_en_q, wr_en_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [REG_W-1:0] rd_q, rd_d;
  flags_t flags_q, flags_d;
  assign accept = bus.in_valid & ~bus.stall & ~bus.flush;
  assign hold = bus.stall & ~bus.flush;
  assign v_new = sovf(bus.in_a_msb, bus.in_b_msb, bus.in_sub, bus.in_raw_msb);
  assign z_new = bus.in_result == '0;
  // next state: stall holds everything, flush/bubble clear valid, data registers load only on accept
  always_comb begin
    valid_d = hold ? valid_q : accept;
    wr_en_d = hold ? wr_en_q : accept & bus.in_wr_en;
    result_d = accept ? bus.in_result : result_q;
    rd_d = accept ? bus.in_rd : rd_q;
    flags_d = !accept ? flags_q :
              bus.in_flag_upd == FLAG_UPD_Z ? {z_new, flags_q.v, flags_q.n} :
              bus.in_flag_upd == FLAG_UPD_ALL ? {z_new, v_new, bus.in_result[DATA_W-1]} : flags_q;
  end
  // stage and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
      result_q <= '0;
      rd_q <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      wr_en_q <= wr_en_d;
      result_q <= result_d;
      rd_q <= rd_d;
      flags_q <= flags_d;
    end
  end
  sat_counter #(.W(SATCNT_W)) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr_i(bus.satcnt_clr),
    .inc_i(accept && bus.in_flag_upd == FLAG_UPD_ALL && v_new),
    .cnt_o(bus.sat_count)
  );
  assign bus.out_valid = valid_q;
  assign bus.out_wr_en = wr_en_q;
  assign bus.out_result = result_q;
  assign bus.out_rd = rd_q;
  assign bus.flag_z = flags_q.z;
  assign bus.flag_v = flags_q.v;
  assign bus.flag_n = flags_q.n;
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: directed table-driven check of the EX flag stage
module tb_ex_flag_stage;
  import ex_flag_stage_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_bad = 0;
  ex_flag_stage_if bus ();
  ex_flag_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    logic [15:0] res;
    logic raw, a, b, sub;
    logic [1:0] upd;
    logic [3:0] rd;
    logic wr, stall, flush, clr;
    logic [40:0] exp;
  } vec_t;
  vec_t vt[14];
  function automatic logic [40:0] ex(logic v, logic [15:0] r, logic [3:0] rd, logic wr, logic z, logic vf, logic n, logic [15:0] c);
    return {v, r, rd, wr, z, vf, n, c};
  endfunction
  function automatic logic [40:0] act();
    return {bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en, bus.flag_z, bus.flag_v, bus.flag_n, bus.sat_count};
  endfunction
  task automatic drive(vec_t t);
    bus.in_valid = t.v;
    bus.in_result = t.res;
    bus.in_raw_msb = t.raw;
    bus.in_a_msb = t.a;
    bus.in_b_msb = t.b;
    bus.in_sub = t.sub;
    bus.in_flag_upd = t.upd;
    bus.in_rd = t.rd;
    bus.in_wr_en = t.wr;
    bus.stall = t.stall;
    bus.flush = t.flush;
    bus.satcnt_clr = t.clr;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string name, logic [40:0] exp);
    n_vec++;
    if (act() !== exp) begin
      n_bad++;
      $display("FAIL %s: got {v,res,rd,we,z,v,n,cnt}=%h expected %h", name, act(), exp);
    end
  endtask
  vec_t ovf;
  initial begin
    ovf = '{1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vt[0]  = '{1, 16'h7FFF, 1, 0, 0, 0, 2'b10, 4'h3, 1, 0, 0, 0, ex(1, 16'h7FFF, 4'h3, 1, 0, 1, 0, 16'd1)};
    vt[1]  = '{1, 16'h0000, 0, 0, 0, 1, 2'b10, 4'h5, 1, 0, 0, 0, ex(1, 16'h0000, 4'h5, 1, 1, 0, 0, 16'd1)};
    vt[2]  = '{1, 16'h8000, 0, 1, 1, 0, 2'b10, 4'h6, 0, 0, 0, 0, ex(1, 16'h8000, 4'h6, 0, 0, 1, 1, 16'd2)};
    vt[3]  = '{1, 16'h0000, 1, 0, 0, 0, 2'b01, 4'h7, 1, 0, 0, 0, ex(1, 16'h0000, 4'h7, 1, 1, 1, 1, 16'd2)};
    vt[4]  = '{1, 16'h1234, 1, 0, 0, 0, 2'b11, 4'h2, 1, 0, 0, 0, ex(1, 16'h1234, 4'h2, 1, 1, 1, 1, 16'd2)};
    vt[5]  = '{0, 16'hABCD, 1, 0, 0, 0, 2'b10, 4'h9, 1, 0, 0, 0, ex(0, 16'h1234, 4'h2, 0, 1, 1, 1, 16'd2)};
    vt[6]  = '{1, 16'h0000, 1, 0, 0, 0, 2'b00, 4'h1, 1, 0, 0, 0, ex(1, 16'h0000, 4'h1, 1, 1, 1, 1, 16'd2)};
    vt[7]  = '{1, 16'h0042, 0, 0, 1, 0, 2'b10, 4'h4, 1, 0, 0, 0, ex(1, 16'h0042, 4'h4, 1, 0, 0, 0, 16'd2)};
    vt[8]  = '{1, 16'hFFFF, 0, 1, 1, 0, 2'b10, 4'h8, 1, 1, 0, 0, ex(1, 16'h0042, 4'h4, 1, 0, 0, 0, 16'd2)};
    vt[9]  = '{1, 16'h0000, 0, 0, 0, 0, 2'b01, 4'hC, 0, 1, 0, 0, ex(1, 16'h0042, 4'h4, 1, 0, 0, 0, 16'd2)};
    vt[10] = '{1, 16'h7FFF, 1, 0, 0, 0, 2'b10, 4'hD, 1, 1, 0, 1, ex(1, 16'h0042, 4'h4, 1, 0, 0, 0, 16'd0)};
    vt[11] = '{1, 16'h7FFF, 1, 0, 0, 0, 2'b10, 4'hF, 1, 1, 1, 0, ex(0, 16'h0042, 4'h4, 0, 0, 0, 0, 16'd0)};
    vt[12] = '{1, 16'h7FFF, 1, 0, 0, 0, 2'b10, 4'hA, 1, 0, 0, 1, ex(1, 16'h7FFF, 4'hA, 1, 0, 1, 0, 16'd0)};
    vt[13] = '{1, 16'h7FFF, 1, 0, 1, 1, 2'b10, 4'hB, 0, 0, 0, 0, ex(1, 16'h7FFF, 4'hB, 0, 0, 1, 0, 16'd1)};
    rst = 1'b1;
    drive(ovf);
    step();
    step();
    check("reset", '0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(vt[i]);
      step();
      check($sformatf("vec%0d", i), vt[i].exp);
    end
    ovf.clr = 1'b1;
    drive(ovf);
    step();
    ovf.clr = 1'b0;
    drive(ovf);
    for (int i = 0; i < 65535; i++) step();
    check("cnt_reach_max", ex(1, 16'h7FFF, 4'h1, 1, 0, 1, 0, 16'hFFFF));
    step();
    check("cnt_stick_max", ex(1, 16'h7FFF, 4'h1, 1, 0, 1, 0, 16'hFFFF));
    ovf.clr = 1'b1;
    drive(ovf);
    step();
    check("cnt_clr_beats_inc", ex(1, 16'h7FFF, 4'h1, 1, 0, 1, 0, 16'd0));
    ovf.clr = 1'b0;
    ovf.v = 1'b0;
    drive(ovf);
    step();
    check("bubble_no_inc", ex(0, 16'h7FFF, 4'h1, 0, 0, 1, 0, 16'd0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
